// File: rtl/mmaps_spi_pkg.sv
// Shared types and constants for the ring-buffer SPI readout path.
// State encoding for the word transmitter and default widths.
package mmaps_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOADED,
        ST_SHIFT,
        ST_DONE
    } spi_tx_state_t;

    localparam int SPI_DATA_W_DEFAULT = 16;
    localparam int SPI_SYNC_MIN       = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pad signal.
// Provides the synchronised level plus one-cycle rise/fall pulses.
module sync_edge
    import mmaps_spi_pkg::*;
#(
    parameter int   STAGES  = SPI_SYNC_MIN,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_word_tx.sv
// SPI-slave word transmitter: fetches ring-buffer words and shifts
// them out MSB-first on MISO, pulsing SPI_done per completed word.
module spi_word_tx
    import mmaps_spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W_DEFAULT,
    parameter int RD_LAT      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              rd_request,
    input  logic              ro_done_n,
    input  logic [DATA_W-1:0] rb_data,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    output logic              spi_miso,
    output logic              SPI_done,
    output logic              busy,
    output logic              underrun
);

    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int FETCH_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam int SYNC_N  = (SYNC_STAGES < SPI_SYNC_MIN) ?
                             SPI_SYNC_MIN : SYNC_STAGES;

    spi_tx_state_t      r_state;
    logic [FETCH_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]  r_shreg;
    logic [DATA_W-1:0]  r_hold;
    logic               r_done;
    logic               r_underrun;

    logic w_sck_lvl;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_lvl;
    logic w_cs_assert;
    logic w_cs_deassert;
    logic w_cs_act;
    logic w_req;
    logic w_clk_act;
    logic w_last;
    logic w_unused;

    sync_edge #(
        .STAGES  (SYNC_N),
        .RST_VAL (1'b0)
    ) u_sync_sck (
        .i_clk   (sysclk),
        .i_rst_n (rst_n),
        .i_async (spi_sck),
        .o_level (w_sck_lvl),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    // cs_n idles high so reset must not fabricate a deassert edge
    sync_edge #(
        .STAGES  (SYNC_N),
        .RST_VAL (1'b1)
    ) u_sync_cs (
        .i_clk   (sysclk),
        .i_rst_n (rst_n),
        .i_async (spi_cs_n),
        .o_level (w_cs_lvl),
        .o_rise  (w_cs_deassert),
        .o_fall  (w_cs_assert)
    );

    assign w_unused  = &{1'b0, w_sck_lvl, w_cs_assert};
    assign w_cs_act  = ~w_cs_lvl;
    assign w_req     = rd_request & ro_done_n;
    assign w_clk_act = w_sck_rise & w_cs_act;
    assign w_last    = (r_bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_fetch_cnt <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_hold      <= '0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_cs_deassert) begin
                r_underrun <= 1'b0;
            end else if (w_clk_act && w_req &&
                         (r_state == ST_FETCH ||
                          r_state == ST_DONE)) begin
                r_underrun <= 1'b1;
            end

            if (!rd_request) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (ro_done_n) begin
                            r_state     <= ST_FETCH;
                            r_fetch_cnt <= FETCH_W'(RD_LAT);
                        end
                    end
                    ST_FETCH: begin
                        if (!ro_done_n) begin
                            r_state <= ST_IDLE;
                        end else if (r_fetch_cnt == '0) begin
                            r_shreg   <= rb_data;
                            r_hold    <= rb_data;
                            r_bit_cnt <= '0;
                            r_state   <= ST_LOADED;
                        end else begin
                            r_fetch_cnt <= r_fetch_cnt - FETCH_W'(1);
                        end
                    end
                    ST_LOADED: begin
                        if (w_cs_deassert) begin
                            r_shreg   <= r_hold;
                            r_bit_cnt <= '0;
                        end else if (!ro_done_n) begin
                            r_state <= ST_IDLE;
                        end else if (w_clk_act) begin
                            r_state   <= ST_SHIFT;
                            r_bit_cnt <= CNT_W'(1);
                        end
                    end
                    ST_SHIFT: begin
                        // abort beats a coincident rise; word is resent
                        if (w_cs_deassert) begin
                            r_shreg   <= r_hold;
                            r_bit_cnt <= '0;
                            r_state   <= ST_LOADED;
                        end else begin
                            if (w_clk_act) begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                                if (w_last) begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                            if (w_sck_fall) begin
                                r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    ST_DONE: begin
                        if (ro_done_n) begin
                            r_state     <= ST_FETCH;
                            r_fetch_cnt <= FETCH_W'(RD_LAT);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi_miso = (r_state == ST_LOADED || r_state == ST_SHIFT) &&
                      w_cs_act && r_shreg[DATA_W-1];
    assign SPI_done = r_done;
    assign busy     = (r_state != ST_IDLE);
    assign underrun = r_underrun;

endmodule

// File: tb/tb_spi_word_tx.sv
// Directed bench for spi_word_tx: a mode-0 SPI master on the pads
// and a small ring-buffer/address-controller model on the data side.
module tb_spi_word_tx;

    logic        sysclk;
    logic        rst_n;
    logic        rd_request;
    logic        ro_done_n;
    logic [15:0] rb_data;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_miso;
    logic        SPI_done;
    logic        busy;
    logic        underrun;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:3];
    int          done_cnt = 0;
    int          base     = 0;
    int          lim      = 0;
    bit          lim_en   = 1'b0;

    spi_word_tx #(
        .DATA_W      (16),
        .RD_LAT      (1),
        .SYNC_STAGES (2)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .rd_request (rd_request),
        .ro_done_n  (ro_done_n),
        .rb_data    (rb_data),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_miso   (spi_miso),
        .SPI_done   (SPI_done),
        .busy       (busy),
        .underrun   (underrun)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // address controller: step on each SPI_done, end after lim words
    always @(negedge sysclk) begin
        int idx;
        if (SPI_done) done_cnt = done_cnt + 1;
        idx = done_cnt - base;
        if (idx > 3) idx = 3;
        if (idx < 0) idx = 0;
        rb_data   = mem[idx];
        ro_done_n = !(lim_en && (done_cnt - base) >= lim);
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic spi_frame(input int nbits, input bit keep_cs,
                             input bit fast, output logic [15:0] word);
        word = 16'h0000;
        @(negedge sysclk);
        spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            wait_neg(8);
            word    = {word[14:0], spi_miso};
            spi_sck = 1'b1;
            if (!(fast && i == nbits - 1)) begin
                wait_neg(8);
                spi_sck = 1'b0;
            end
        end
        if (!fast) begin
            wait_neg(8);
            if (!keep_cs) begin
                spi_cs_n = 1'b1;
                wait_neg(8);
            end
        end
    endtask

    task automatic load_words(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
        mem[3] = w3;
        base   = done_cnt;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        rd_request = 1'b0;
        spi_sck    = 1'b0;
        spi_cs_n   = 1'b1;
        load_words(16'h0, 16'h0, 16'h0, 16'h0);
        wait_neg(4);
        checks++;
        if (spi_miso !== 1'b0) begin
            failures++;
            $display("FAIL reset_miso got=%b exp=0", spi_miso);
        end
        checks++;
        if (SPI_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", SPI_done);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_underrun got=%b exp=0", underrun);
        end
        rst_n = 1'b1;
        wait_neg(2);
    endtask

    task automatic test_single_word;
        logic [15:0] w;
        int d0;
        d0 = done_cnt;
        load_words(16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3);
        rd_request = 1'b1;
        wait_neg(6);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy got=%b exp=1", busy);
        end
        spi_frame(16, 1'b0, 1'b0, w);
        checks++;
        if (w !== 16'hA5C3) begin
            failures++;
            $display("FAIL single_word got=%h exp=a5c3", w);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL single_done got=%0d exp=1", done_cnt - d0);
        end
        rd_request = 1'b0;
        wait_neg(4);
    endtask

    task automatic test_burst;
        logic [15:0] w;
        logic [15:0] exp_w [0:2];
        int d0;
        exp_w[0] = 16'h0001;
        exp_w[1] = 16'h8000;
        exp_w[2] = 16'hFFFF;
        d0 = done_cnt;
        load_words(16'h0001, 16'h8000, 16'hFFFF, 16'h1111);
        lim        = 3;
        lim_en     = 1'b1;
        rd_request = 1'b1;
        wait_neg(6);
        for (int k = 0; k < 3; k++) begin
            spi_frame(16, 1'b0, 1'b0, w);
            checks++;
            if (w !== exp_w[k]) begin
                failures++;
                $display("FAIL burst_word%0d got=%h exp=%h", k, w, exp_w[k]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL burst_idle got=%b exp=0", busy);
        end
        spi_frame(16, 1'b0, 1'b0, w);
        checks++;
        if (w !== 16'h0000) begin
            failures++;
            $display("FAIL burst_fourth got=%h exp=0000", w);
        end
        checks++;
        if (done_cnt - d0 != 3) begin
            failures++;
            $display("FAIL burst_done got=%0d exp=3", done_cnt - d0);
        end
        rd_request = 1'b0;
        lim_en     = 1'b0;
        wait_neg(4);
    endtask

    task automatic test_abort;
        logic [15:0] w;
        int d0;
        d0 = done_cnt;
        load_words(16'h1234, 16'h1234, 16'h1234, 16'h1234);
        rd_request = 1'b1;
        wait_neg(6);
        spi_frame(7, 1'b1, 1'b0, w);
        spi_cs_n = 1'b1;
        wait_neg(10);
        checks++;
        if (w !== 16'h0009) begin
            failures++;
            $display("FAIL abort_partial got=%h exp=0009", w);
        end
        spi_frame(16, 1'b0, 1'b0, w);
        checks++;
        if (w !== 16'h1234) begin
            failures++;
            $display("FAIL abort_resend got=%h exp=1234", w);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL abort_done got=%0d exp=1", done_cnt - d0);
        end
        rd_request = 1'b0;
        wait_neg(4);
    endtask

    task automatic test_underrun;
        logic [15:0] w;
        int d0;
        d0 = done_cnt;
        load_words(16'hC0DE, 16'h7777, 16'h7777, 16'h7777);
        rd_request = 1'b1;
        wait_neg(6);
        spi_frame(16, 1'b1, 1'b1, w);
        @(negedge sysclk);
        spi_sck = 1'b0;
        @(negedge sysclk);
        spi_sck = 1'b1;
        wait_neg(20);
        checks++;
        if (w !== 16'hC0DE) begin
            failures++;
            $display("FAIL underrun_word got=%h exp=c0de", w);
        end
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_set got=%b exp=1", underrun);
        end
        spi_sck = 1'b0;
        wait_neg(10);
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_held got=%b exp=1", underrun);
        end
        spi_cs_n = 1'b1;
        wait_neg(6);
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL underrun_clear got=%b exp=0", underrun);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL underrun_done got=%0d exp=1", done_cnt - d0);
        end
        rd_request = 1'b0;
        wait_neg(4);
    endtask

    task automatic test_reset_mid_word;
        logic [15:0] w;
        int d0;
        d0 = done_cnt;
        load_words(16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h5A5A);
        rd_request = 1'b1;
        wait_neg(6);
        spi_frame(5, 1'b1, 1'b0, w);
        rst_n = 1'b0;
        @(negedge sysclk);
        checks++;
        if ({spi_miso, SPI_done, busy, underrun} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_outputs got=%b exp=0000",
                     {spi_miso, SPI_done, busy, underrun});
        end
        rst_n    = 1'b1;
        spi_cs_n = 1'b1;
        wait_neg(10);
        checks++;
        if (done_cnt - d0 != 0) begin
            failures++;
            $display("FAIL midrst_nodone got=%0d exp=0", done_cnt - d0);
        end
        spi_frame(16, 1'b0, 1'b0, w);
        checks++;
        if (w !== 16'h5A5A) begin
            failures++;
            $display("FAIL midrst_fresh got=%h exp=5a5a", w);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL midrst_done got=%0d exp=1", done_cnt - d0);
        end
        rd_request = 1'b0;
        wait_neg(4);
    endtask

    task automatic test_rd_request_drop;
        logic [15:0] w;
        int d0;
        d0 = done_cnt;
        load_words(16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C);
        rd_request = 1'b1;
        wait_neg(6);
        spi_frame(10, 1'b1, 1'b0, w);
        rd_request = 1'b0;
        @(negedge sysclk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_busy got=%b exp=0", busy);
        end
        checks++;
        if (spi_miso !== 1'b0) begin
            failures++;
            $display("FAIL drop_miso got=%b exp=0", spi_miso);
        end
        checks++;
        if (w !== 16'h00F0) begin
            failures++;
            $display("FAIL drop_bits got=%h exp=00f0", w);
        end
        spi_cs_n = 1'b1;
        wait_neg(10);
        checks++;
        if (done_cnt - d0 != 0) begin
            failures++;
            $display("FAIL drop_done got=%0d exp=0", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_burst;
        test_abort;
        test_underrun;
        test_reset_mid_word;
        test_rd_request_drop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
